// File: rtl/key_sw_pkg.sv
// Shared types and constants for KEY/SW input conditioning.
// Debounce state encoding, 50 MHz cycle defaults and a width helper.
package key_sw_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } db_state_t;

  localparam int unsigned DB_10MS = 500000;
  localparam int unsigned LONG_1S = 50000000;

  // Bits needed to hold values 0..v-1, never less than 1.
  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One-bit conditioner: two-flop synchroniser followed by a counter debounce FSM.
// level holds the accepted value; upd is high for the cycle level first shows a new value.
//
//   state  | meaning
//   STABLE | synchronised input matches level, counter idle
//   CHECK  | input differs from level, counting consecutive stable cycles
module debounce_cell
  import key_sw_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_10MS,
  parameter bit          RESET_VAL = 1'b0,
  parameter bit          INVERT    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic upd
);

  localparam int unsigned CW = clog2(64'(DB_CYCLES) + 64'd1);

  logic          sync_q1, sync_q2, sync;
  db_state_t     state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= RESET_VAL;
      sync_q2 <= RESET_VAL;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  assign sync = sync_q2 ^ INVERT;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    case (state)
      STABLE: begin
        cnt_d = '0;
        if (sync != level) begin
          // A one-cycle window means the first differing cycle is already enough.
          if (DB_CYCLES == 1) begin
            accept = 1'b1;
          end else begin
            state_d = CHECK;
            cnt_d   = CW'(1);
          end
        end
      end
      CHECK: begin
        if (sync == level) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt == CW'(DB_CYCLES - 1)) begin
          accept  = 1'b1;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= STABLE;
      cnt   <= '0;
      level <= 1'b0;
      upd   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      upd   <= accept;
      if (accept) level <= sync;
    end
  end

endmodule

// File: rtl/key_sw_conditioner.sv
// Conditions DE10-Nano KEY/SW pins into clean levels and single-cycle event pulses.
// Per-bit debouncing happens in debounce_cell; hold timing and event pulses live here.
module key_sw_conditioner
  import key_sw_pkg::*;
#(
  parameter int unsigned N_KEY       = 2,
  parameter int unsigned N_SW        = 4,
  parameter int unsigned DB_CYCLES   = DB_10MS,
  parameter int unsigned LONG_CYCLES = LONG_1S
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_KEY-1:0] key_n_in,
  input  logic [N_SW-1:0]  sw_in,
  output logic [N_KEY-1:0] key_level,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release,
  output logic [N_KEY-1:0] key_long,
  output logic [N_SW-1:0]  sw_level,
  output logic             sw_change
);

  localparam int unsigned HW = clog2(64'(LONG_CYCLES) + 64'd1);

  logic [N_KEY-1:0] key_upd;
  logic [N_SW-1:0]  sw_upd;

  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    logic [HW-1:0] hold;
    logic          long_q;

    // Keys are active-low on the pins; the cell inverts so level 1 means pressed.
    debounce_cell #(
      .DB_CYCLES (DB_CYCLES),
      .RESET_VAL (1'b1),
      .INVERT    (1'b1)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (key_n_in[i]),
      .level (key_level[i]),
      .upd   (key_upd[i])
    );

    // Saturating hold counter: the pulse fires on the step into LONG_CYCLES only.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hold   <= '0;
        long_q <= 1'b0;
      end else if (!key_level[i]) begin
        hold   <= '0;
        long_q <= 1'b0;
      end else begin
        long_q <= (hold == HW'(LONG_CYCLES - 1));
        if (hold != HW'(LONG_CYCLES)) hold <= hold + HW'(1);
      end
    end

    assign key_press[i]   = key_upd[i] & key_level[i];
    assign key_release[i] = key_upd[i] & ~key_level[i];
    assign key_long[i]    = long_q;
  end

  for (genvar j = 0; j < N_SW; j++) begin : g_sw
    debounce_cell #(
      .DB_CYCLES (DB_CYCLES),
      .RESET_VAL (1'b0),
      .INVERT    (1'b0)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (sw_in[j]),
      .level (sw_level[j]),
      .upd   (sw_upd[j])
    );
  end

  assign sw_change = |sw_upd;

endmodule

// File: tb/tb_key_sw_conditioner.sv
// Directed bench for key_sw_conditioner with DB_CYCLES=4, LONG_CYCLES=20.
// Inputs change 1 time unit after a rising edge; that edge is called edge 0.
module tb_key_sw_conditioner;

  logic       FPGA_CLK1_50;
  logic       reset;
  logic [1:0] key_n_in;
  logic [3:0] sw_in;
  logic [1:0] key_level, key_press, key_release, key_long;
  logic [3:0] sw_level;
  logic       sw_change;

  int checks   = 0;
  int failures = 0;

  key_sw_conditioner #(
    .N_KEY       (2),
    .N_SW        (4),
    .DB_CYCLES   (4),
    .LONG_CYCLES (20)
  ) dut (
    .clk         (FPGA_CLK1_50),
    .reset       (reset),
    .key_n_in    (key_n_in),
    .sw_in       (sw_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long),
    .sw_level    (sw_level),
    .sw_change   (sw_change)
  );

  initial FPGA_CLK1_50 = 1'b0;
  always #5 FPGA_CLK1_50 = ~FPGA_CLK1_50;

  task automatic tick();
    @(posedge FPGA_CLK1_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {19'd0, key_level, key_press, key_release, key_long, sw_level, sw_change};
  endfunction

  // Press key 0 at edge 0, release the pin at edge rel; check key 0 events edge by edge.
  task automatic press_hold(input int rel);
    key_n_in[0] = 1'b0;
    for (int e = 1; e <= rel + 10; e++) begin
      tick();
      if (e == rel) key_n_in[0] = 1'b1;
      chk($sformatf("hold%0d_lvl_e%0d", rel, e), {30'd0, key_level},
          (e >= 6 && e < rel + 6) ? 32'd1 : 32'd0);
      chk($sformatf("hold%0d_press_e%0d", rel, e), {30'd0, key_press},
          (e == 6) ? 32'd1 : 32'd0);
      chk($sformatf("hold%0d_rel_e%0d", rel, e), {30'd0, key_release},
          (e == rel + 6) ? 32'd1 : 32'd0);
      chk($sformatf("hold%0d_long_e%0d", rel, e), {30'd0, key_long},
          (e == 26 && rel >= 20) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    reset    = 1'b1;
    key_n_in = 2'b11;
    sw_in    = 4'b0000;
    tick();
    tick();
    chk("reset_outs", all_outs(), 32'd0);
    reset = 1'b0;
    for (int e = 0; e < 10; e++) tick();
    chk("idle_outs", all_outs(), 32'd0);

    // Clean press into a 30-cycle hold: long fires at edge 26, release at 36.
    press_hold(30);
    // Short 10-cycle hold: no long pulse.
    press_hold(10);

    // Bounce on key 1: low 3 cycles, high 1, then low steady from edge 4.
    key_n_in[1] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 3) key_n_in[1] = 1'b1;
      if (e == 4) key_n_in[1] = 1'b0;
      chk($sformatf("bounce_press_e%0d", e), {30'd0, key_press},
          (e == 10) ? 32'd2 : 32'd0);
      chk($sformatf("bounce_lvl_e%0d", e), {30'd0, key_level},
          (e >= 10) ? 32'd2 : 32'd0);
    end
    key_n_in[1] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("k1_release_e%0d", e), {30'd0, key_release},
          (e == 6) ? 32'd2 : 32'd0);
    end
    chk("k1_released_lvl", {30'd0, key_level}, 32'd0);

    // Two switches flipped on the same edge give one change pulse.
    sw_in = 4'b1001;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("sw_lvl_e%0d", e), {28'd0, sw_level},
          (e >= 6) ? 32'h9 : 32'h0);
      chk($sformatf("sw_chg_e%0d", e), {31'd0, sw_change},
          (e == 6) ? 32'd1 : 32'd0);
    end

    // Reset while key 0 is in its debounce window.
    key_n_in[0] = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("midreset_outs", all_outs(), 32'd0);
    tick();
    chk("midreset_held_outs", all_outs(), 32'd0);
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("postrst_klvl_e%0d", e), {30'd0, key_level},
          (e >= 6) ? 32'd1 : 32'd0);
      chk($sformatf("postrst_press_e%0d", e), {30'd0, key_press},
          (e == 6) ? 32'd1 : 32'd0);
      chk($sformatf("postrst_swlvl_e%0d", e), {28'd0, sw_level},
          (e >= 6) ? 32'h9 : 32'h0);
      chk($sformatf("postrst_swchg_e%0d", e), {31'd0, sw_change},
          (e == 6) ? 32'd1 : 32'd0);
    end

    // Power-up with switch 2 already on.
    reset    = 1'b1;
    key_n_in = 2'b11;
    sw_in    = 4'b0100;
    tick();
    tick();
    chk("pwrup_reset_outs", all_outs(), 32'd0);
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("pwrup_swlvl_e%0d", e), {28'd0, sw_level},
          (e >= 6) ? 32'h4 : 32'h0);
      chk($sformatf("pwrup_swchg_e%0d", e), {31'd0, sw_change},
          (e == 6) ? 32'd1 : 32'd0);
      chk($sformatf("pwrup_keys_e%0d", e),
          {24'd0, key_level, key_press, key_release, key_long}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
